// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D/E/M/W hazard signals between datapath (master) and hazard unit (slave)
interface hazard_scoreboard_if #(
    parameter int AW = 4,
    parameter int CW = 16
);
    logic [AW-1:0] RA1D;
    logic [AW-1:0] RA2D;
    logic [AW-1:0] WA3D;
    logic          RegWriteD;
    logic [1:0]    LatClassD;
    logic          PCSrcD;
    logic [AW-1:0] RA1E;
    logic [AW-1:0] RA2E;
    logic [AW-1:0] WA3M;
    logic [AW-1:0] WA3W;
    logic          RegWriteM;
    logic          RegWriteW;
    logic          BranchTakenE;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic [CW-1:0] StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, LatClassD, PCSrcD,
        output RA1E, RA2E, WA3M, WA3W, RegWriteM, RegWriteW, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, LatClassD, PCSrcD,
        input  RA1E, RA2E, WA3M, WA3W, RegWriteM, RegWriteW, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, countdown register scoreboard and PC-write FSM for a 5-stage pipeline
module hazard_scoreboard #(
    parameter int NREGS   = 16,
    parameter int AW      = 4,
    parameter int LD_LAT  = 1,
    parameter int MUL_LAT = 3,
    parameter int PC_LAT  = 3,
    parameter int PC_REG  = 15,
    parameter int CW      = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int MAXL = (LD_LAT > MUL_LAT) ? LD_LAT : MUL_LAT;
    localparam int SW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);
    localparam int PW   = (PC_LAT < 1) ? 1 : $clog2(PC_LAT + 1);
    localparam logic [AW-1:0] PCR = AW'(PC_REG);

    typedef enum logic {IDLE, PCW} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_cnt_q, pc_cnt_d;
    logic [SW-1:0] cnt_q [NREGS];
    logic [SW-1:0] cnt_d [NREGS];
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [SW-1:0] lat_d;
    logic          raw_a, raw_b, waw, stall_d, pcw, issue, pc_go;

    // Producer latency of the D instruction and the resulting stall/issue decisions
    always_comb begin
        lat_d   = (hz.LatClassD == 2'd1) ? SW'(LD_LAT) : (hz.LatClassD == 2'd2) ? SW'(MUL_LAT) : '0;
        pcw     = state_q == PCW;
        raw_a   = hz.RA1D != PCR && cnt_q[hz.RA1D] != '0;
        raw_b   = hz.RA2D != PCR && cnt_q[hz.RA2D] != '0;
        waw     = hz.RegWriteD && hz.WA3D != PCR && cnt_q[hz.WA3D] > lat_d;
        stall_d = raw_a | raw_b | waw;
        issue   = hz.RegWriteD & ~stall_d & ~hz.BranchTakenE & ~pcw;
        pc_go   = hz.PCSrcD & ~stall_d & ~hz.BranchTakenE & ~pcw;
    end

    // E-stage forward selects: M beats W, the PC register is never forwarded
    always_comb begin
        hz.ForwardAE = (hz.RA1E == PCR) ? 2'b00 :
                       (hz.RegWriteM && hz.RA1E == hz.WA3M) ? 2'b10 :
                       (hz.RegWriteW && hz.RA1E == hz.WA3W) ? 2'b01 : 2'b00;
        hz.ForwardBE = (hz.RA2E == PCR) ? 2'b00 :
                       (hz.RegWriteM && hz.RA2E == hz.WA3M) ? 2'b10 :
                       (hz.RegWriteW && hz.RA2E == hz.WA3W) ? 2'b01 : 2'b00;
    end

    // Scoreboard countdown: an issue reload wins over the per-cycle decrement
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - SW'(1) : '0;
            if (issue && hz.WA3D == AW'(r) && r != PC_REG) cnt_d[r] = lat_d;
        end
    end

    // PC-write FSM: hold PCW for PC_LAT cycles after the writer leaves D
    always_comb begin
        state_d  = state_q;
        pc_cnt_d = pc_cnt_q;
        if (state_q == IDLE) begin
            state_d  = pc_go ? PCW : IDLE;
            pc_cnt_d = pc_go ? PW'(PC_LAT) : pc_cnt_q;
        end else begin
            pc_cnt_d = pc_cnt_q - PW'(1);
            state_d  = (pc_cnt_q == PW'(1)) ? IDLE : PCW;
        end
    end

    // Pipeline control outputs and the saturating stall counter
    always_comb begin
        hz.StallD   = stall_d;
        hz.StallF   = stall_d | (hz.PCSrcD & ~pcw) | (pcw & (pc_cnt_q > PW'(1)));
        hz.FlushD   = hz.BranchTakenE | (hz.PCSrcD & ~pcw & ~stall_d) | pcw;
        hz.FlushE   = stall_d | hz.BranchTakenE;
        hz.StallCount = stall_cnt_q;
        stall_cnt_d = (stall_d && stall_cnt_q != '1) ? stall_cnt_q + CW'(1) : stall_cnt_q;
    end

    // State registers; reset drops all pending producers and any PC write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            pc_cnt_q    <= pc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized run against a ready-time reference model
module tb_hazard_scoreboard;
    localparam int AW = 4, NREGS = 16, LD = 1, MUL = 3, PCL = 3, PCR = 15, CW = 8;
    localparam int SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW), .CW(CW)) hz ();

    hazard_scoreboard #(
        .NREGS(NREGS), .AW(AW), .LD_LAT(LD), .MUL_LAT(MUL),
        .PC_LAT(PCL), .PC_REG(PCR), .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    int errors = 0;
    int checks = 0;

    // Model: each register is busy until an absolute cycle; PC write busy through pc_end
    int ready [NREGS];
    int pc_end = -10;
    int scount = 0;
    int cyc = 0;
    logic e_stalld, e_stallf, e_flushd, e_flushe;
    logic [1:0] e_fa, e_fb;
    logic [CW-1:0] e_cnt;

    function automatic int rem(input logic [AW-1:0] r);
        if (int'(r) == PCR) return 0;
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    function automatic int lat(input logic [1:0] c);
        return (c == 2'd1) ? LD : (c == 2'd2) ? MUL : 0;
    endfunction

    function automatic logic [1:0] fwd(input logic [AW-1:0] ra);
        if (int'(ra) == PCR) return 2'b00;
        if (hz.RegWriteM && ra == hz.WA3M) return 2'b10;
        if (hz.RegWriteW && ra == hz.WA3W) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit in_pcw();
        return cyc <= pc_end;
    endfunction

    task automatic model_eval();
        bit p;
        p = in_pcw();
        e_stalld = rem(hz.RA1D) > 0 || rem(hz.RA2D) > 0 ||
                   (hz.RegWriteD && int'(hz.WA3D) != PCR && rem(hz.WA3D) > lat(hz.LatClassD));
        e_stallf = e_stalld || (hz.PCSrcD && !p) || (p && cyc < pc_end);
        e_flushd = hz.BranchTakenE || (hz.PCSrcD && !p && !e_stalld) || p;
        e_flushe = e_stalld || hz.BranchTakenE;
        e_fa = fwd(hz.RA1E);
        e_fb = fwd(hz.RA2E);
        e_cnt = CW'(scount);
    endtask

    task automatic model_update();
        bit go;
        if (reset) begin
            foreach (ready[r]) ready[r] = 0;
            pc_end = -10;
            scount = 0;
        end else begin
            go = !e_stalld && !hz.BranchTakenE && !in_pcw();
            if (go && hz.RegWriteD && int'(hz.WA3D) != PCR) ready[hz.WA3D] = cyc + 1 + lat(hz.LatClassD);
            if (go && hz.PCSrcD) pc_end = cyc + PCL;
            if (e_stalld && scount < SMAX) scount++;
        end
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        hz.RA1D = '0; hz.RA2D = '0; hz.WA3D = '0; hz.RegWriteD = 1'b0; hz.LatClassD = 2'd0;
        hz.PCSrcD = 1'b0; hz.RA1E = '0; hz.RA2E = '0; hz.WA3M = '0; hz.WA3W = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.BranchTakenE = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000000",
                     {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE});
        end
        checks++;
        if (hz.StallCount !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", hz.StallCount); end
    endtask

    task automatic test_forward();
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd1; hz.RegWriteW = 1'b1; hz.WA3W = 4'd1; hz.RA1E = 4'd1; hz.RA2E = 4'd1;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_a_m got=%b want=10", hz.ForwardAE); end
        checks++;
        if (hz.ForwardBE !== 2'b10) begin errors++; $display("FAIL fwd_b_m got=%b want=10", hz.ForwardBE); end
        hz.RegWriteM = 1'b0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_a_w got=%b want=01", hz.ForwardAE); end
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd15; hz.WA3W = 4'd15; hz.RA1E = 4'd15; hz.RA2E = 4'd3;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_pc got=%b want=00", hz.ForwardAE); end
        hz.WA3W = 4'd3;
        #1;
        checks++;
        if (hz.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_w got=%b want=01", hz.ForwardBE); end
        drive_idle();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        hz.RegWriteD = 1'b1; hz.WA3D = 4'd2; hz.LatClassD = 2'd1;
        #1;
        checks++;
        if (hz.StallD !== 1'b0) begin errors++; $display("FAIL lu_issue got=%b want=0", hz.StallD); end
        tick();
        hz.RegWriteD = 1'b0; hz.RA1D = 4'd2;
        #1;
        checks++;
        if ({hz.StallD, hz.StallF, hz.FlushE} !== 3'b111) begin
            errors++; $display("FAIL lu_stall got=%b want=111", {hz.StallD, hz.StallF, hz.FlushE});
        end
        tick();
        #1;
        checks++;
        if (hz.StallD !== 1'b0) begin errors++; $display("FAIL lu_release got=%b want=0", hz.StallD); end
        checks++;
        if (hz.StallCount !== CW'(1)) begin errors++; $display("FAIL lu_count got=%0d want=1", hz.StallCount); end
        drive_idle();
        tick();
    endtask

    task automatic test_mul();
        do_reset();
        hz.RegWriteD = 1'b1; hz.WA3D = 4'd4; hz.LatClassD = 2'd2;
        tick();
        hz.RegWriteD = 1'b0; hz.RA2D = 4'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (hz.StallD !== (i < 3)) begin errors++; $display("FAIL mul_raw%0d got=%b want=%b", i, hz.StallD, i < 3); end
            tick();
        end
        hz.RA2D = 4'd0; hz.RegWriteD = 1'b1; hz.WA3D = 4'd4; hz.LatClassD = 2'd2;
        tick();
        hz.LatClassD = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (hz.StallD !== (i < 3)) begin errors++; $display("FAIL mul_waw%0d got=%b want=%b", i, hz.StallD, i < 3); end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_pc();
        do_reset();
        hz.PCSrcD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({hz.StallF, hz.FlushD, hz.FlushE} !== {i < 3, i < 4, 1'b0}) begin
                errors++;
                $display("FAIL pc_cyc%0d got=%b want=%b", i, {hz.StallF, hz.FlushD, hz.FlushE}, {i < 3, i < 4, 1'b0});
            end
            tick();
            hz.PCSrcD = 1'b0;
        end
    endtask

    task automatic test_branch();
        do_reset();
        hz.RegWriteD = 1'b1; hz.WA3D = 4'd5; hz.LatClassD = 2'd1; hz.BranchTakenE = 1'b1;
        #1;
        checks++;
        if ({hz.FlushD, hz.FlushE} !== 2'b11) begin errors++; $display("FAIL br_flush got=%b want=11", {hz.FlushD, hz.FlushE}); end
        tick();
        drive_idle();
        hz.RA1D = 4'd5;
        #1;
        checks++;
        if (hz.StallD !== 1'b0) begin errors++; $display("FAIL br_nostall got=%b want=0", hz.StallD); end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        hz.RegWriteD = 1'b1; hz.WA3D = 4'd3; hz.LatClassD = 2'd2; hz.PCSrcD = 1'b1;
        tick();
        drive_idle();
        tick();
        hz.RA1D = 4'd3;
        #1;
        checks++;
        if ({hz.StallD, hz.StallF, hz.FlushD} !== 3'b111) begin
            errors++; $display("FAIL rm_pre got=%b want=111", {hz.StallD, hz.StallF, hz.FlushD});
        end
        hz.RA1D = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hz.RA1D = 4'd3;
        #1;
        checks++;
        if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.StallCount} !== '0) begin
            errors++;
            $display("FAIL rm_post got=%b cnt=%0d want=0", {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, hz.StallCount);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_saturate();
        int nstall;
        nstall = 0;
        do_reset();
        hz.RegWriteD = 1'b1; hz.WA3D = 4'd4; hz.LatClassD = 2'd2; hz.RA1D = 4'd4;
        for (int i = 0; i < 2000 && nstall < SMAX + 6; i++) begin
            #1;
            model_eval();
            checks++;
            if (hz.StallD !== e_stalld || hz.StallCount !== e_cnt) begin
                errors++;
                $display("FAIL sat_cyc%0d stall=%b cnt=%0d want stall=%b cnt=%0d", i, hz.StallD, hz.StallCount, e_stalld, e_cnt);
            end
            if (e_stalld) nstall++;
            tick();
        end
        #1;
        checks++;
        if (nstall < SMAX + 6 || hz.StallCount !== CW'(SMAX)) begin
            errors++; $display("FAIL sat_final stalls=%0d cnt=%0d want cnt=%0d", nstall, hz.StallCount, SMAX);
        end
        drive_idle();
        tick();
    endtask

    function automatic logic [AW-1:0] rreg();
        int v;
        v = $urandom_range(0, 5);
        return (v == 5) ? AW'(PCR) : AW'(v);
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            hz.RA1D = rreg(); hz.RA2D = rreg(); hz.WA3D = rreg();
            hz.RegWriteD = 1'($urandom_range(0, 1)); hz.LatClassD = 2'($urandom_range(0, 3));
            hz.PCSrcD = ($urandom_range(0, 11) == 0);
            hz.BranchTakenE = !in_pcw() && ($urandom_range(0, 9) == 0);
            hz.RA1E = rreg(); hz.RA2E = rreg(); hz.WA3M = rreg(); hz.WA3W = rreg();
            hz.RegWriteM = 1'($urandom_range(0, 1)); hz.RegWriteW = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 99) == 0);
            #1;
            model_eval();
            checks++;
            if ({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.StallCount} !==
                {e_fa, e_fb, e_stallf, e_stalld, e_flushd, e_flushe, e_cnt}) begin
                errors++;
                $display("FAIL rand_cyc%0d got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cnt=%0d want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cnt=%0d",
                         i, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.StallCount,
                         e_fa, e_fb, e_stallf, e_stalld, e_flushd, e_flushe, e_cnt);
            end
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        foreach (ready[r]) ready[r] = 0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_mul();
        test_pc();
        test_branch();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
